// File: rtl/l1ca_acq_ctrl.sv
// l1ca_acq_ctrl: SV sweep controller for l1ca_search with thresholded detection FIFO
module l1ca_acq_ctrl #(
   parameter int SV_FIRST   = 1,
   parameter int SV_LAST    = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        go,
   input  logic        abort,
   input  logic [31:0] threshold,
   output logic        busy,
   output logic        sweep_done,
   output logic        srch_start,
   output logic [5:0]  srch_sv,
   input  logic [31:0] srch_acc,
   input  logic [10:0] srch_code_index,
   input  logic [4:0]  srch_dop_index,
   input  logic        srch_done,
   output logic        det_valid,
   input  logic        det_ready,
   output logic [5:0]  det_sv,
   output logic [10:0] det_code,
   output logic [4:0]  det_dop,
   output logic [31:0] det_power,
   output logic [5:0]  det_count,
   output logic        overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [2:0] {IDLE, START, WAIT_CLR, WAIT_DONE, EVAL, NEXT, DRAIN} state_t;
   state_t      r_state;
   logic        r_abort_pend, r_clr_seen, r_start, r_sweep_done, r_overflow;
   logic [5:0]  r_sv, r_count;
   logic [53:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr, r_rd;
   logic [AW:0] r_cnt;
   logic        w_abort, w_detect, w_full, w_pop, w_push, w_drop, w_flush;
   assign w_abort  = abort | r_abort_pend;
   assign w_detect = srch_acc > threshold;
   assign w_full   = r_cnt == (AW+1)'(FIFO_DEPTH);
   assign w_flush  = (r_state == IDLE) & go;
   assign w_pop    = det_valid & det_ready & ~w_flush;
   assign w_push   = (r_state == EVAL) & w_detect & (~w_full | w_pop);
   assign w_drop   = (r_state == EVAL) & w_detect & w_full & ~w_pop;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_sv         <= 6'(SV_FIRST);
         r_start      <= 1'b0;
         r_sweep_done <= 1'b0;
         r_abort_pend <= 1'b0;
         r_clr_seen   <= 1'b0;
         r_count      <= '0;
         r_overflow   <= 1'b0;
      end else begin
         r_start      <= 1'b0;
         r_sweep_done <= 1'b0;
         if (abort && r_state != IDLE) r_abort_pend <= 1'b1;
         case (r_state)
            IDLE: begin
               r_abort_pend <= 1'b0;
               if (go) begin
                  r_state    <= START;
                  r_start    <= 1'b1;
                  r_sv       <= 6'(SV_FIRST);
                  r_count    <= '0;
                  r_overflow <= 1'b0;
               end
            end
            START: begin
               r_state    <= w_abort ? DRAIN : WAIT_CLR;
               r_clr_seen <= 1'b0;
            end
            WAIT_CLR: begin
               r_state    <= w_abort ? DRAIN : (srch_done ? WAIT_CLR : WAIT_DONE);
               r_clr_seen <= ~srch_done;
            end
            WAIT_DONE: begin
               r_state    <= w_abort ? DRAIN : (srch_done ? EVAL : WAIT_DONE);
               r_clr_seen <= 1'b1;
            end
            EVAL: begin
               if (w_push && r_count != 6'd63) r_count <= r_count + 6'd1;
               if (w_drop) r_overflow <= 1'b1;
               r_state <= NEXT;
            end
            NEXT: begin
               if (w_abort || r_sv == 6'(SV_LAST)) begin
                  r_sweep_done <= 1'b1;
                  r_state      <= IDLE;
               end else begin
                  r_sv    <= r_sv + 6'd1;
                  r_start <= 1'b1;
                  r_state <= START;
               end
            end
            DRAIN: begin
               if (!r_clr_seen) r_clr_seen <= ~srch_done;
               else if (srch_done) begin
                  r_sweep_done <= 1'b1;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst || w_flush) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         r_wr  <= w_push ? r_wr + 1'b1 : r_wr;
         r_rd  <= w_pop ? r_rd + 1'b1 : r_rd;
         r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= {r_sv, srch_code_index, srch_dop_index, srch_acc};
   end
   assign {det_sv, det_code, det_dop, det_power} = r_mem[r_rd];
   assign det_valid  = r_cnt != '0;
   assign busy       = r_state != IDLE;
   assign sweep_done = r_sweep_done;
   assign srch_start = r_start;
   assign srch_sv    = r_sv;
   assign det_count  = r_count;
   assign overflow   = r_overflow;
endmodule
